// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_queue
// Purpose  : Per-thread instruction FIFOs between fetch and decode with
//            round-robin presentation, back-pressure and branch flush.
// Revision : 1.0
// ============================================================================
module fetch_decode_queue #(
  parameter  int NUM_THREADS = 4,
  parameter  int DEPTH       = 4,
  parameter  int SKID        = 2,
  parameter  int INSTR_W     = 32,
  parameter  int PC_W        = 32,
  localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_fetch_instr_valid,
  input  logic [INSTR_W-1:0]     i_fetch_instr_data,
  input  logic [PC_W-1:0]        i_fetch_instr_pc,
  input  logic [TID_W-1:0]       i_fetch_thread_id,
  input  logic [NUM_THREADS-1:0] i_flush,
  output logic [NUM_THREADS-1:0] o_stall_fetch,
  input  logic                   i_dec_ready,
  output logic                   o_dec_valid,
  output logic [INSTR_W-1:0]     o_dec_instr_data,
  output logic [PC_W-1:0]        o_dec_instr_pc,
  output logic [TID_W-1:0]       o_dec_thread_id,
  output logic                   o_overflow_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]   r_wr       [NUM_THREADS];
  logic [PTR_W-1:0]   r_rd       [NUM_THREADS];
  logic [INSTR_W-1:0] r_mem_data [NUM_THREADS][DEPTH];
  logic [PC_W-1:0]    r_mem_pc   [NUM_THREADS][DEPTH];
  logic [TID_W-1:0]   r_last_grant;
  logic [TID_W-1:0]   r_lock_tid;
  logic               r_lock;
  logic               r_overflow;

  logic [PTR_W-1:0]       w_occ [NUM_THREADS];
  logic [NUM_THREADS-1:0] w_full;
  logic [NUM_THREADS-1:0] w_elig;
  logic [TID_W-1:0]       w_cand;
  logic [TID_W-1:0]       w_sel;
  logic [AW-1:0]          w_head;
  logic                   w_dec_valid;
  logic                   w_pop;
  logic                   w_pop_same;
  logic                   w_push_req;
  logic                   w_push_acc;
  logic                   w_push_drop;

  generate
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_status
      assign w_occ[t]         = r_wr[t] - r_rd[t];
      assign w_full[t]        = (w_occ[t] == PTR_W'(DEPTH));
      assign w_elig[t]        = (w_occ[t] != '0) && !i_flush[t];
      assign o_stall_fetch[t] = (w_occ[t] >= PTR_W'(DEPTH - SKID));
    end
  endgenerate

  // A presented-but-unaccepted thread keeps the output until taken or flushed,
  // so late arrivals on other threads cannot disturb a held instruction.
  always_comb begin
    w_dec_valid = 1'b0;
    w_sel       = '0;
    w_cand      = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      w_cand = TID_W'((int'(r_last_grant) + i) % NUM_THREADS);
      if (w_elig[w_cand]) begin
        w_dec_valid = 1'b1;
        w_sel       = w_cand;
      end
    end
    if (r_lock && w_elig[r_lock_tid]) begin
      w_dec_valid = 1'b1;
      w_sel       = r_lock_tid;
    end
  end

  assign w_pop       = w_dec_valid & i_dec_ready;
  assign w_pop_same  = w_pop && (w_sel == i_fetch_thread_id);
  assign w_push_req  = i_fetch_instr_valid & ~i_flush[i_fetch_thread_id];
  assign w_push_acc  = w_push_req & (~w_full[i_fetch_thread_id] | w_pop_same);
  assign w_push_drop = w_push_req & w_full[i_fetch_thread_id] & ~w_pop_same;

  generate
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_wr[t] <= '0;
          r_rd[t] <= '0;
        end else begin
          if (w_push_acc && (i_fetch_thread_id == TID_W'(t))) begin
            r_wr[t] <= r_wr[t] + 1'b1;
          end
          if (i_flush[t]) begin
            r_rd[t] <= r_wr[t];
          end else if (w_pop && (w_sel == TID_W'(t))) begin
            r_rd[t] <= r_rd[t] + 1'b1;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (w_push_acc) begin
      r_mem_data[i_fetch_thread_id][r_wr[i_fetch_thread_id][AW-1:0]] <= i_fetch_instr_data;
      r_mem_pc[i_fetch_thread_id][r_wr[i_fetch_thread_id][AW-1:0]]   <= i_fetch_instr_pc;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_grant <= TID_W'(NUM_THREADS - 1);
      r_lock       <= 1'b0;
      r_lock_tid   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_last_grant <= w_sel;
      end
      r_lock     <= w_dec_valid & ~i_dec_ready;
      r_lock_tid <= w_sel;
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head           = r_rd[w_sel][AW-1:0];
  assign o_dec_valid      = w_dec_valid;
  assign o_dec_instr_data = r_mem_data[w_sel][w_head];
  assign o_dec_instr_pc   = r_mem_pc[w_sel][w_head];
  assign o_dec_thread_id  = w_sel;
  assign o_overflow_err   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_queue
// Purpose  : Directed bench for fetch_decode_queue with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_fetch_decode_queue;
  localparam int NT = 4, DEPTH = 4, SKID = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fvalid;
  logic [31:0] fdata, fpc;
  logic [1:0]  ftid;
  logic [3:0]  flush;
  logic [3:0]  stall;
  logic        dec_ready, dec_valid, ovf;
  logic [31:0] dec_data, dec_pc;
  logic [1:0]  dec_tid;

  int n_vec = 0;
  int n_err = 0;

  fetch_decode_queue #(.NUM_THREADS(NT), .DEPTH(DEPTH), .SKID(SKID),
                       .INSTR_W(32), .PC_W(32)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_fetch_instr_valid(fvalid), .i_fetch_instr_data(fdata),
    .i_fetch_instr_pc(fpc), .i_fetch_thread_id(ftid),
    .i_flush(flush), .o_stall_fetch(stall),
    .i_dec_ready(dec_ready), .o_dec_valid(dec_valid),
    .o_dec_instr_data(dec_data), .o_dec_instr_pc(dec_pc),
    .o_dec_thread_id(dec_tid), .o_overflow_err(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each thread is a plain queue of {pc, data}
  logic [63:0] m_q [NT][$];
  int m_last     = NT - 1;
  bit m_lock     = 1'b0;
  int m_lock_tid = 0;
  bit m_ovf      = 1'b0;

  function automatic void model_sel(output bit v, output int s);
    v = 1'b0;
    s = 0;
    if (m_lock && m_q[m_lock_tid].size() > 0 && !flush[m_lock_tid]) begin
      v = 1'b1;
      s = m_lock_tid;
      return;
    end
    for (int i = 1; i <= NT; i++) begin
      int t;
      t = (m_last + i) % NT;
      if (m_q[t].size() > 0 && !flush[t]) begin
        v = 1'b1;
        s = t;
        return;
      end
    end
  endfunction

  always @(posedge clk) begin : model_update
    bit v;
    int s;
    logic [63:0] e;
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) m_q[t].delete();
      m_last = NT - 1;
      m_lock = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      model_sel(v, s);
      if (v && dec_ready) begin
        e = m_q[s].pop_front();
        m_last = s;
      end
      for (int t = 0; t < NT; t++) if (flush[t]) m_q[t].delete();
      if (fvalid && !flush[ftid]) begin
        if (m_q[ftid].size() < DEPTH) m_q[ftid].push_back({fpc, fdata});
        else m_ovf = 1'b1;
      end
      m_lock     = v && !dec_ready;
      m_lock_tid = s;
    end
  end

  always @(negedge clk) begin : compare
    bit v;
    int s;
    logic [63:0] e;
    if (!rst_n) begin
      chk("rst_valid", dec_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ovf", ovf, 0);
    end else begin
      model_sel(v, s);
      chk("dec_valid", dec_valid, v);
      if (v) begin
        e = m_q[s][0];
        chk("dec_tid", dec_tid, s);
        chk("dec_pc", dec_pc, e[63:32]);
        chk("dec_data", dec_data, e[31:0]);
      end
      for (int t = 0; t < NT; t++)
        chk($sformatf("stall%0d", t), stall[t], m_q[t].size() >= DEPTH - SKID);
      chk("overflow", ovf, m_ovf);
    end
  end

  task automatic drive(input bit v, input int tid, input logic [31:0] pc, input logic [31:0] d);
    fvalid = v;
    ftid   = 2'(tid);
    fpc    = pc;
    fdata  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int tid, input logic [31:0] pc);
    drive(1, tid, pc, pc ^ 32'hA5A5_0000);
    step();
  endtask

  int          exp_tid [6] = '{0, 2, 3, 0, 2, 3};
  logic [31:0] exp_pc  [6] = '{32'h3000, 32'h3100, 32'h3200, 32'h3004, 32'h3104, 32'h3204};

  initial begin
    rst_n = 1'b0; dec_ready = 1'b0; flush = '0;
    drive(0, 0, 0, 0);
    step(); step();
    rst_n = 1'b1;
    chk("reset_valid", dec_valid, 0);
    chk("reset_stall", stall, 0);
    chk("reset_ovf", ovf, 0);

    // Single push, 1-cycle latency
    dec_ready = 1'b1;
    drive(1, 0, 32'h1000, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0);
    chk("single_valid", dec_valid, 1);
    chk("single_tid", dec_tid, 0);
    chk("single_pc", dec_pc, 32'h1000);
    chk("single_data", dec_data, 32'hDEADBEEF);
    step();
    chk("single_drained", dec_valid, 0);

    // Round-robin over threads 0, 2, 3
    dec_ready = 1'b0;
    push(0, 32'h3000); push(0, 32'h3004);
    push(2, 32'h3100); push(2, 32'h3104);
    push(3, 32'h3200); push(3, 32'h3204);
    drive(0, 0, 0, 0);
    dec_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_tid%0d", k), dec_tid, exp_tid[k]);
      chk($sformatf("rr_pc%0d", k), dec_pc, exp_pc[k]);
      step();
    end
    chk("rr_empty", dec_valid, 0);

    // Flush thread 2 with a simultaneous push to it
    dec_ready = 1'b0;
    push(2, 32'h4000); push(2, 32'h4004); push(2, 32'h4008);
    push(0, 32'h5000);
    drive(1, 2, 32'h4100, 32'h0);
    flush = 4'b0100;
    #1;
    chk("flush_cycle_tid", dec_tid, 0);
    chk("flush_cycle_pc", dec_pc, 32'h5000);
    step();
    flush = '0;
    drive(0, 0, 0, 0);
    chk("flush_stall2", stall[2], 0);
    chk("flush_model_q2", m_q[2].size(), 0);
    chk("flush_t0_kept", dec_pc, 32'h5000);
    dec_ready = 1'b1;
    step();
    chk("flush_gone1", dec_valid, 0);
    step();
    chk("flush_gone2", dec_valid, 0);

    // Full queue: push and pop on the same thread in one cycle
    dec_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(0, 32'h6000 + 32'(4 * k));
    drive(0, 0, 0, 0);
    chk("full_stall0", stall[0], 1);
    chk("full_model_q0", m_q[0].size(), 4);
    dec_ready = 1'b1;
    push(0, 32'h6010);
    drive(0, 0, 0, 0);
    chk("pushpop_ovf", ovf, 0);
    chk("pushpop_stall0", stall[0], 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("pushpop_pc%0d", k), dec_pc, 32'h6000 + 32'(4 * k));
      step();
    end
    chk("pushpop_empty", dec_valid, 0);

    // Fill thread 1 past capacity
    dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(1, 32'h2000 + 32'(4 * k));
      if (k == 0) chk("fill_stall_k0", stall[1], 0);
      if (k == 1) chk("fill_stall_k1", stall[1], 1);
      if (k == 3) chk("fill_ovf_k3", ovf, 0);
      if (k == 4) chk("fill_ovf_k4", ovf, 1);
    end
    drive(0, 0, 0, 0);
    chk("fill_model_q1", m_q[1].size(), 4);
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_pc%0d", k), dec_pc, 32'h2000 + 32'(4 * k));
      step();
    end
    chk("fill_empty", dec_valid, 0);
    chk("fill_ovf_sticky", ovf, 1);

    // Asynchronous reset mid-stream
    dec_ready = 1'b0;
    push(3, 32'h8000); push(3, 32'h8004); push(3, 32'h8008);
    drive(0, 0, 0, 0);
    chk("pre_rst_stall3", stall[3], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", dec_valid, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    push(1, 32'h7000);
    drive(0, 0, 0, 0);
    chk("post_rst_valid", dec_valid, 1);
    chk("post_rst_tid", dec_tid, 1);
    chk("post_rst_pc", dec_pc, 32'h7000);
    dec_ready = 1'b1;
    step();
    chk("post_rst_empty", dec_valid, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
